// File: rtl/reg_file_pkg.sv
// Shared state type, constants and read-select rule for reg_file_mp.
// Optional feature: define REG_FILE_ZERO_REG_EN to hardwire register 0 to zero.
package reg_file_pkg;

   localparam int ST_W = 1;

   typedef enum logic [ST_W-1:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } clr_state_e;

   typedef enum logic [1:0] {
      SEL_ZERO,
      SEL_BYP,
      SEL_MEM
   } rd_sel_e;

`ifdef REG_FILE_ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   localparam int unsigned SWEEP_START = ZERO_REG ? 1 : 0;

   function automatic rd_sel_e rd_sel(
      input int unsigned addr,
      input int unsigned depth,
      input logic        wr_ok,
      input int unsigned wr_addr
   );
      if (addr >= depth || (ZERO_REG && addr == 0)) return SEL_ZERO;
      if (wr_ok && wr_addr == addr) return SEL_BYP;
      return SEL_MEM;
   endfunction

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: walks the array one register per cycle while BUSY.
// With REG_FILE_ZERO_REG_EN the walk skips register 0.
module reg_file_clr_seq
   import reg_file_pkg::*;
#(
   parameter  int DEPTH  = 4,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(SWEEP_START);
   localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DEPTH - 1);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = SWEEP;
               idx_d   = IDX_FIRST;
            end
         end
         SWEEP: begin
            if (idx_q == IDX_LAST) begin
               state_d = IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + ADDR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q == SWEEP);
   assign clr_we   = busy;
   assign clr_addr = idx_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: one write port, two registered read ports, clear engine.
// Optional feature: REG_FILE_ZERO_REG_EN makes register 0 read as zero.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter  int WIDTH  = 8,
   parameter  int DEPTH  = 4,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              WR_EN,
   input  logic [ADDR_W-1:0] DIR_WR,
   input  logic [WIDTH-1:0]  DI,
   input  logic              RD_EN,
   input  logic [ADDR_W-1:0] DIR_A,
   input  logic [ADDR_W-1:0] DIR_B,
   output logic [WIDTH-1:0]  DOA,
   output logic [WIDTH-1:0]  DOB,
   input  logic              CLR,
   output logic              BUSY
);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [WIDTH-1:0]  mem_d [DEPTH];
   logic [WIDTH-1:0]  doa_q, doa_d;
   logic [WIDTH-1:0]  dob_q, dob_d;
   logic [WIDTH-1:0]  mem_a, mem_b;
   logic              busy, clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              wr_ok, rd_ok;
   rd_sel_e           sel_a, sel_b;

   reg_file_clr_seq #(
      .DEPTH (DEPTH)
   ) u_clr_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (CLR),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // CLR beats a same-cycle write; range check happens before any indexing
   assign wr_ok = WR_EN && !busy && !CLR
                  && (32'(DIR_WR) < DEPTH)
                  && !(ZERO_REG && DIR_WR == '0);
   assign rd_ok = RD_EN && !busy;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (clr_we && 32'(clr_addr) == i) begin
            mem_d[i] = '0;
         end else if (wr_ok && 32'(DIR_WR) == i) begin
            mem_d[i] = DI;
         end
         if (ZERO_REG && i == 0) mem_d[i] = '0;
      end
   end

   always_comb begin
      mem_a = '0;
      mem_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (32'(DIR_A) == i) mem_a = mem_q[i];
         if (32'(DIR_B) == i) mem_b = mem_q[i];
      end
      sel_a = rd_sel(32'(DIR_A), DEPTH, wr_ok, 32'(DIR_WR));
      sel_b = rd_sel(32'(DIR_B), DEPTH, wr_ok, 32'(DIR_WR));
   end

   always_comb begin
      doa_d = doa_q;
      dob_d = dob_q;
      if (rd_ok) begin
         case (sel_a)
            SEL_ZERO: doa_d = '0;
            SEL_BYP:  doa_d = DI;
            default:  doa_d = mem_a;
         endcase
         case (sel_b)
            SEL_ZERO: dob_d = '0;
            SEL_BYP:  dob_d = DI;
            default:  dob_d = mem_b;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         doa_q <= '0;
         dob_q <= '0;
      end else begin
         mem_q <= mem_d;
         doa_q <= doa_d;
         dob_q <= dob_d;
      end
   end

   assign DOA  = doa_q;
   assign DOB  = dob_q;
   assign BUSY = busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: 4x8 instance against a reference model, 5x16 instance by hand.
module tb_reg_file_mp;

`ifdef REG_FILE_ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif
   localparam int D4 = 4;
   localparam int D5 = 5;
   localparam int START = ZR ? 1 : 0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        we4 = 0, re4 = 0, clr4 = 0;
   logic [1:0]  wa4 = 0, a4 = 0, b4 = 0;
   logic [7:0]  di4 = 0;
   logic [7:0]  doa4, dob4;
   logic        busy4;

   logic        we5 = 0, re5 = 0, clr5 = 0;
   logic [2:0]  wa5 = 0, a5 = 0, b5 = 0;
   logic [15:0] di5 = 0;
   logic [15:0] doa5, dob5;
   logic        busy5;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   reg_file_mp u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .WR_EN(we4), .DIR_WR(wa4), .DI(di4),
      .RD_EN(re4), .DIR_A(a4), .DIR_B(b4),
      .DOA(doa4), .DOB(dob4),
      .CLR(clr4), .BUSY(busy4)
   );

   reg_file_mp #(.WIDTH(16), .DEPTH(D5)) u_dut5 (
      .clk(clk), .rst_n(rst_n),
      .WR_EN(we5), .DIR_WR(wa5), .DI(di5),
      .RD_EN(re5), .DIR_A(a5), .DIR_B(b5),
      .DOA(doa5), .DOB(dob5),
      .CLR(clr5), .BUSY(busy5)
   );

   // reference model of the 4x8 instance
   logic [7:0] m [D4];
   logic [7:0] mdoa, mdob;
   int left, sidx;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < D4; i++) m[i] = 8'h00;
      mdoa = 8'h00;
      mdob = 8'h00;
      left = 0;
      sidx = 0;
   endtask

   function automatic logic [7:0] mval(int x, logic acc, int wa,
                                       logic [7:0] di);
      if (ZR && x == 0) return 8'h00;
      if (x >= D4) return 8'h00;
      if (acc && wa == x) return di;
      return m[x];
   endfunction

   task automatic model_edge(logic we, int wa, logic [7:0] di, logic re,
                             int a, int b, logic clr);
      logic acc;
      if (left > 0) begin
         m[sidx] = 8'h00;
         sidx++;
         left--;
      end else begin
         acc = we && !clr && wa < D4 && !(ZR && wa == 0);
         if (re) begin
            mdoa = mval(a, acc, wa, di);
            mdob = mval(b, acc, wa, di);
         end
         if (acc) m[wa] = di;
         if (clr) begin
            left = D4 - START;
            sidx = START;
         end
      end
   endtask

   task automatic step(logic we, int wa, logic [7:0] di, logic re,
                       int a, int b, logic clr);
      we4 = we; wa4 = wa[1:0]; di4 = di;
      re4 = re; a4 = a[1:0]; b4 = b[1:0];
      clr4 = clr;
      @(posedge clk);
      model_edge(we, wa, di, re, a, b, clr);
      #1;
      chk("doa", 32'(doa4), 32'(mdoa));
      chk("dob", 32'(dob4), 32'(mdob));
      chk("busy", 32'(busy4), (left > 0) ? 32'd1 : 32'd0);
   endtask

   task automatic step5(logic we, int wa, logic [15:0] di, logic re,
                        int a, int b, logic clr);
      we5 = we; wa5 = wa[2:0]; di5 = di;
      re5 = re; a5 = a[2:0]; b5 = b[2:0];
      clr5 = clr;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       we;
      int         wa;
      logic [7:0] di;
      logic       re;
      int         a;
      int         b;
      logic [7:0] ea;
      logic [7:0] eb;
   } vec_t;

   vec_t tbl [10];
   int nb;

   initial begin
      tbl[0] = '{1'b1, 2, 8'hA5, 1'b0, 0, 0, 8'h00, 8'h00};
      tbl[1] = '{1'b0, 0, 8'h00, 1'b1, 2, 0, 8'hA5, 8'h00};
      tbl[2] = '{1'b1, 1, 8'h3C, 1'b1, 1, 2, 8'h3C, 8'hA5};
      tbl[3] = '{1'b0, 0, 8'h00, 1'b1, 1, 1, 8'h3C, 8'h3C};
      tbl[4] = '{1'b1, 3, 8'h5A, 1'b0, 0, 0, 8'h3C, 8'h3C};
      tbl[5] = '{1'b0, 0, 8'h00, 1'b1, 3, 2, 8'h5A, 8'hA5};
      tbl[6] = '{1'b1, 3, 8'hC3, 1'b1, 3, 3, 8'hC3, 8'hC3};
      tbl[7] = '{1'b0, 0, 8'h00, 1'b1, 0, 3, 8'h00, 8'hC3};
      tbl[8] = '{1'b1, 0, 8'h77, 1'b1, 0, 1,
                 ZR ? 8'h00 : 8'h77, 8'h3C};
      tbl[9] = '{1'b0, 0, 8'h00, 1'b1, 0, 0,
                 ZR ? 8'h00 : 8'h77, ZR ? 8'h00 : 8'h77};

      model_reset();
      #1;
      chk("rst_doa", 32'(doa4), 32'h0);
      chk("rst_dob", 32'(dob4), 32'h0);
      chk("rst_busy", 32'(busy4), 32'h0);
      chk("rst_busy5", 32'(busy5), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].we, tbl[i].wa, tbl[i].di, tbl[i].re,
              tbl[i].a, tbl[i].b, 1'b0);
         chk("tbl_doa", 32'(doa4), 32'(tbl[i].ea));
         chk("tbl_dob", 32'(dob4), 32'(tbl[i].eb));
      end

      // fill, then sweep while hammering writes and reads
      for (int i = 0; i < D4; i++)
         step(1'b1, i, 8'(17 * (i + 1)), 1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 8'h00, 1'b1, 1, 2, 1'b0);
      step(1'b0, 0, 8'h00, 1'b0, 0, 0, 1'b1);
      nb = busy4 ? 1 : 0;
      for (int k = 0; k < 20 && busy4; k++) begin
         step(1'b1, k % 4, 8'hEE, 1'b1, k % 4, (k + 1) % 4, 1'b0);
         if (busy4) nb++;
      end
      chk("busy_len", 32'(nb), 32'(D4 - START));
      chk("held_doa", 32'(doa4), 32'h22);
      chk("held_dob", 32'(dob4), 32'h33);
      for (int i = 0; i < D4; i++) begin
         step(1'b0, 0, 8'h00, 1'b1, i, i, 1'b0);
         chk("clr_zero", 32'(doa4), 32'h0);
      end

      // CLR with a same-cycle write: write dropped, read sees old data
      step(1'b1, 3, 8'h44, 1'b0, 0, 0, 1'b0);
      step(1'b1, 3, 8'hFF, 1'b1, 3, 3, 1'b1);
      chk("clr_wr_rd", 32'(doa4), 32'h44);
      for (int k = 0; k < 20 && busy4; k++)
         step(1'b0, 0, 8'h00, 1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 8'h00, 1'b1, 3, 2, 1'b0);
      chk("clr_wr_drop", 32'(doa4), 32'h0);

      // async reset in the middle of a sweep
      step(1'b1, 1, 8'h9A, 1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 8'h00, 1'b1, 1, 1, 1'b0);
      step(1'b0, 0, 8'h00, 1'b0, 0, 0, 1'b1);
      step(1'b0, 0, 8'h00, 1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 8'h00, 1'b0, 0, 0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy4), 32'h0);
      chk("mid_rst_doa", 32'(doa4), 32'h0);
      chk("mid_rst_dob", 32'(dob4), 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 0, 8'h00, 1'b1, 1, 2, 1'b0);
      chk("post_rst_rd", 32'(doa4), 32'h0);

      // random traffic against the model
      for (int n = 0; n < 400; n++)
         step(1'($urandom_range(0, 1)), $urandom_range(0, 3),
              8'($urandom), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 15) == 0));
      step(1'b0, 0, 8'h00, 1'b0, 0, 0, 1'b0);
      for (int k = 0; k < 20 && busy4; k++)
         step(1'b0, 0, 8'h00, 1'b0, 0, 0, 1'b0);

      // 5x16 instance: out-of-range addresses and non-power-of-2 depth
      step5(1'b1, 7, 16'h1234, 1'b0, 0, 0, 1'b0);
      step5(1'b0, 0, 16'h0000, 1'b1, 2, 3, 1'b0);
      chk("d5_alias_a", 32'(doa5), 32'h0);
      chk("d5_alias_b", 32'(dob5), 32'h0);
      step5(1'b1, 4, 16'hBEEF, 1'b0, 0, 0, 1'b0);
      step5(1'b0, 0, 16'h0000, 1'b1, 4, 6, 1'b0);
      chk("d5_rd4", 32'(doa5), 32'hBEEF);
      chk("d5_rd6", 32'(dob5), 32'h0);
      step5(1'b1, 4, 16'hCAFE, 1'b1, 4, 7, 1'b0);
      chk("d5_byp", 32'(doa5), 32'hCAFE);
      chk("d5_rd7", 32'(dob5), 32'h0);
      step5(1'b0, 0, 16'h0000, 1'b1, 7, 4, 1'b0);
      chk("d5_rd4b", 32'(dob5), 32'hCAFE);
      step5(1'b0, 0, 16'h0000, 1'b0, 0, 0, 1'b1);
      nb = busy5 ? 1 : 0;
      for (int k = 0; k < 20 && busy5; k++) begin
         step5(1'b0, 0, 16'h0000, 1'b0, 0, 0, 1'b0);
         if (busy5) nb++;
      end
      chk("d5_busy_len", 32'(nb), 32'(D5 - START));
      step5(1'b0, 0, 16'h0000, 1'b1, 4, 4, 1'b0);
      chk("d5_clr", 32'(doa5), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
